uart_cts_tx: RTL

Host-side UART transmitter that drives the board's rxd line. It is the far end of the board link: it serialises bytes from a valid/ready stream into 8N1 frames. It obeys the board's nrts output as its active-low clear-to-send, and never starts a frame while the board's RX path is full. Used in the host-emulation bench harness and in board-to-board bridge builds.

---
 rtl/uart_cts_tx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_cts_tx.sv
// uart_cts_tx: host-side 8N1 UART transmitter with active-low clear-to-send.
// Takes bytes from a valid/ready stream and serialises them LSB first.
// A new frame only starts when the synchronised ncts shows clear-to-send.
// Back-to-back frames leave no idle gap between frames.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s).
module uart_cts_tx #(
    parameter int PRESCALER = 24,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 ncts,
    output logic                 tx,
    output logic                 busy
);

    localparam int CNT_W = $clog2(PRESCALER);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PRESCALER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       LAST_DATA  = 3'(DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP  = 3'(STOP_BITS - 1);

    logic [2:0]           state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [2:0]           idx_reg, idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 tx_reg, tx_next;
    logic                 ncts_meta_reg, ncts_sync_reg;
`ifdef UART_TX_PARITY_EN
    logic                 parity_reg, parity_next;
`endif

    logic cts_ok;
    logic bit_end;
    logic last_stop_cycle;
    logic handshake;

    // Two-flop synchroniser for the asynchronous clear-to-send; resets to "not clear".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ncts_meta_reg <= 1'b1;
            ncts_sync_reg <= 1'b1;
        end else begin
            ncts_meta_reg <= ncts;
            ncts_sync_reg <= ncts_meta_reg;
        end
    end

    assign cts_ok          = ~ncts_sync_reg;
    assign bit_end         = (cnt_reg == '0);
    assign last_stop_cycle = (state_reg == ST_STOP) && bit_end && (idx_reg == LAST_STOP);

    // Ready only at frame boundaries, and only while the far end is clear to receive.
    assign tx_ready  = cts_ok && ((state_reg == ST_IDLE) || last_stop_cycle);
    assign handshake = tx_valid && tx_ready;
    assign busy      = (state_reg != ST_IDLE);
    assign tx        = tx_reg;

    // Next-state logic: bit timing, shifting and the line level for the next cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
            end

            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                    idx_next   = 3'd0;
                    cnt_next   = CNT_RELOAD;
                    tx_next    = shift_reg[0];
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    cnt_next   = CNT_RELOAD;
                    if (idx_reg == LAST_DATA) begin
                        idx_next = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
                        tx_next    = parity_reg;
`else
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        idx_next = idx_reg + 3'd1;
                        // The bit after the shift is the one currently in position 1.
                        tx_next  = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                    idx_next   = 3'd0;
                    cnt_next   = CNT_RELOAD;
                    tx_next    = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
`endif

            ST_STOP: begin
                tx_next = 1'b1;
                if (bit_end) begin
                    if (idx_reg == LAST_STOP) begin
                        state_next = ST_IDLE;
                        idx_next   = 3'd0;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                        cnt_next = CNT_RELOAD;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                idx_next   = 3'd0;
                tx_next    = 1'b1;
            end
        endcase

        // A handshake can only occur in IDLE or the final stop cycle, so it
        // overrides whatever the frame logic chose and starts a fresh frame.
        if (handshake) begin
            state_next = ST_START;
            cnt_next   = CNT_RELOAD;
            idx_next   = 3'd0;
            shift_next = tx_data;
            tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_next = ^tx_data;
`endif
        end
    end

    // Frame state registers; reset forces the line high immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= 3'd0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the latched byte, captured on the handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= parity_next;
        end
    end
`endif

endmodule
